// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I(M) control FSM
//
// Sequences each instruction through FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB]
// and drives the datapath strobes and selects for the current step.
//
// Parameters
//   ENABLE_MUL   1 = decode MUL/MULH/MULHSU/MULHU, 0 = those encodings are illegal
//   MEM_TIMEOUT  wait cycles allowed for imem/dmem ready (0 = wait forever)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   op, func3, func7           instruction fields from the instruction register
//   alu_zero, alu_last_bit     ALU flags, sampled in EXECUTE for branches
//   imem_ready, dmem_ready     memory completion strobes
//   mul_done                   multiplier result valid
//   imem_req, ir_write         fetch request / instruction register load
//   mem_read, mem_write        data memory access strobes
//   reg_write, pc_write        register file / PC update strobes
//   alu_ctrl, imm_src, alu_src, write_back_src, pc_src, second_add_src
//                              datapath selects
//   illegal, bus_err           sticky trap causes
//   instret                    retired-instruction counter (counts pc_write cycles)
//   state                      current FSM state
//
// Select encodings
//   imm_src        000 I, 001 S, 010 B, 011 J, 100 U
//   alu_src        0 rs2, 1 immediate
//   write_back_src 00 ALU result, 01 load data, 10 PC+4, 11 second adder
//   pc_src         0 PC+4, 1 second adder target
//   second_add_src 00 PC+imm, 01 rs1+imm, 10 0+imm
module multicycle_controller #(
    parameter int ENABLE_MUL  = 0,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             alu_zero,
    input  logic             alu_last_bit,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             mul_done,
    output logic             imem_req,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       imm_src,
    output logic             alu_src,
    output logic [1:0]       write_back_src,
    output logic             pc_src,
    output logic [1:0]       second_add_src,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_SA  = 2'b11;

    localparam logic [1:0] SA_PC   = 2'b00;
    localparam logic [1:0] SA_RS1  = 2'b01;
    localparam logic [1:0] SA_ZERO = 2'b10;

    localparam bit MUL_ON     = (ENABLE_MUL != 0);
    localparam bit TIMEOUT_ON = (MEM_TIMEOUT > 0);
    localparam int WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    // The counter holds the number of non-ready cycles already seen, so the
    // cycle that finds it at MEM_TIMEOUT-1 is the one that reaches the limit.
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        TIMEOUT_ON ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    // Decoded instruction class and selects
    logic               is_load, is_store, is_branch, is_jump, is_mul, enc_bad;
    logic [3:0]         alu_ctrl_dec;
    logic [2:0]         imm_src_dec;
    logic               alu_src_dec;
    logic [1:0]         wb_src_dec;
    logic [1:0]         sa_src_dec;
    logic               branch_taken;

    function automatic logic [3:0] alu_base(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    always_comb begin
        is_load      = 1'b0;
        is_store     = 1'b0;
        is_branch    = 1'b0;
        is_jump      = 1'b0;
        is_mul       = 1'b0;
        enc_bad      = 1'b0;
        alu_ctrl_dec = ALU_ADD;
        imm_src_dec  = IMM_I;
        alu_src_dec  = 1'b0;
        wb_src_dec   = WB_ALU;
        sa_src_dec   = SA_PC;
        case (op)
            OP_LOAD: begin
                is_load     = 1'b1;
                alu_src_dec = 1'b1;
                wb_src_dec  = WB_MEM;
                enc_bad     = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
            end
            OP_STORE: begin
                is_store    = 1'b1;
                imm_src_dec = IMM_S;
                alu_src_dec = 1'b1;
                enc_bad     = (func3 > 3'b010);
            end
            OP_BRANCH: begin
                is_branch   = 1'b1;
                imm_src_dec = IMM_B;
                enc_bad     = (func3 == 3'b010) || (func3 == 3'b011);
                // Signed compares use SLT, unsigned SLTU, equality SUB.
                case (func3[2:1])
                    2'b10:   alu_ctrl_dec = ALU_SLT;
                    2'b11:   alu_ctrl_dec = ALU_SLTU;
                    default: alu_ctrl_dec = ALU_SUB;
                endcase
            end
            OP_JALR: begin
                is_jump     = 1'b1;
                alu_src_dec = 1'b1;
                wb_src_dec  = WB_PC4;
                sa_src_dec  = SA_RS1;
                enc_bad     = (func3 != 3'b000);
            end
            OP_JAL: begin
                is_jump     = 1'b1;
                imm_src_dec = IMM_J;
                wb_src_dec  = WB_PC4;
            end
            OP_IMM: begin
                alu_src_dec  = 1'b1;
                // func7 is part of the immediate except for the shift forms.
                alu_ctrl_dec = alu_base(func3, (func3 == 3'b101) && (func7 == F7_ALT));
                if (func3 == 3'b001) begin
                    enc_bad = (func7 != F7_BASE);
                end else if (func3 == 3'b101) begin
                    enc_bad = (func7 != F7_BASE) && (func7 != F7_ALT);
                end
            end
            OP_REG: begin
                if (func7 == F7_BASE) begin
                    alu_ctrl_dec = alu_base(func3, 1'b0);
                end else if (func7 == F7_ALT) begin
                    alu_ctrl_dec = alu_base(func3, 1'b1);
                    enc_bad      = (func3 != 3'b000) && (func3 != 3'b101);
                end else if (func7 == F7_MULDIV && MUL_ON && !func3[2]) begin
                    is_mul       = 1'b1;
                    alu_ctrl_dec = ALU_MUL + {2'b00, func3[1:0]};
                end else begin
                    enc_bad = 1'b1;
                end
            end
            OP_LUI: begin
                imm_src_dec = IMM_U;
                wb_src_dec  = WB_SA;
                sa_src_dec  = SA_ZERO;
            end
            OP_AUIPC: begin
                imm_src_dec = IMM_U;
                wb_src_dec  = WB_SA;
            end
            default: enc_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (func3)
            3'b000:          branch_taken = alu_zero;
            3'b001:          branch_taken = ~alu_zero;
            3'b100, 3'b110:  branch_taken = alu_last_bit;
            3'b101, 3'b111:  branch_taken = ~alu_last_bit;
            default:         branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        illegal_d      = illegal_q;
        bus_err_d      = bus_err_q;
        imem_req       = 1'b0;
        ir_write       = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        reg_write      = 1'b0;
        pc_write       = 1'b0;
        pc_src         = 1'b0;
        alu_ctrl       = 4'b0000;
        imm_src        = 3'b000;
        alu_src        = 1'b0;
        write_back_src = 2'b00;
        second_add_src = 2'b00;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (TIMEOUT_ON && wait_cnt_q == WAIT_LAST) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else if (TIMEOUT_ON) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (enc_bad) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_load || is_store) begin
                    state_d    = S_MEM;
                    wait_cnt_d = '0;
                end else if (is_branch) begin
                    pc_write   = 1'b1;
                    pc_src     = branch_taken;
                    state_d    = S_FETCH;
                    wait_cnt_d = '0;
                end else if (is_mul) begin
                    if (mul_done) begin
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_read  = is_load;
                mem_write = is_store;
                if (dmem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_write   = 1'b1;
                        state_d    = S_FETCH;
                        wait_cnt_d = '0;
                    end
                end else if (TIMEOUT_ON && wait_cnt_q == WAIT_LAST) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else if (TIMEOUT_ON) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = is_jump;
                state_d    = S_FETCH;
                wait_cnt_d = '0;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d    = S_FETCH;
                wait_cnt_d = '0;
            end
        endcase

        // Selects only follow the instruction register once it holds a decoded
        // instruction; elsewhere they sit at a known zero.
        if (state_q == S_DECODE || state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB) begin
            alu_ctrl       = alu_ctrl_dec;
            imm_src        = imm_src_dec;
            alu_src        = alu_src_dec;
            write_back_src = wb_src_dec;
            second_add_src = sa_src_dec;
        end

        // Reset abandons any access in flight within the same cycle.
        if (rst) begin
            imem_req       = 1'b0;
            ir_write       = 1'b0;
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            reg_write      = 1'b0;
            pc_write       = 1'b0;
            pc_src         = 1'b0;
            alu_ctrl       = 4'b0000;
            imm_src        = 3'b000;
            alu_src        = 1'b0;
            write_back_src = 2'b00;
            second_add_src = 2'b00;
        end

        instret_d = pc_write ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
            instret_q  <= instret_d;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ENABLE_MUL, default 0: 1 = decode RV32M multiply (MUL/MULH/MULHSU/MULHU); 0 = treat as illegal.
REQ-002 Parameter MEM_TIMEOUT, default 16: max wait cycles for imem/dmem ready; 0 disables timeout.
REQ-003 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 op  in  7; func3  in  3; func7  in  7: instruction fields from instruction register, stable from DECODE until retirement.
REQ-007 alu_zero  in  1; alu_last_bit  in  1: ALU flags, valid in EXECUTE.
REQ-008 imem_ready  in  1; dmem_ready  in  1: memory completion strobes.
REQ-009 mul_done  in  1: multiplier result valid.
REQ-010 imem_req  out  1; ir_write  out  1; mem_read  out  1; mem_write  out  1; reg_write  out  1; pc_write  out  1.
REQ-011 alu_ctrl  out  4; imm_src  out  3; alu_src  out  1; write_back_src  out  2; pc_src  out  1; second_add_src  out  2: datapath selects, same encodings as existing single-cycle controller.
REQ-012 illegal  out  1; bus_err  out  1; instret  out  CNT_W; state  out  3.

Function
REQ-013 States (state encoding): FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.
REQ-014 FETCH: imem_req=1; on imem_ready -> ir_write=1 for that cycle, next DECODE; else stay.
REQ-015 DECODE: one cycle; illegal encoding -> TRAP with illegal=1; else -> EXECUTE.
REQ-016 Illegal: unknown opcode; load func3 in {011,110,111}; store func3 > 010; branch func3 in {010,011}; JALR func3 != 000; shift-imm bad func7; R-type func7 not in {0000000,0100000} or 0100000 with func3 not in {000,101}; func7=0000001 when ENABLE_MUL=0 or func3[2]=1.
REQ-017 EXECUTE: load/store -> MEM; branch -> FETCH with pc_write=1, pc_src = branch outcome; ALU/U/J -> WB.
REQ-018 Branch outcome: BEQ alu_zero; BNE ~alu_zero; BLT/BLTU alu_last_bit; BGE/BGEU ~alu_last_bit; JAL/JALR pc_src=1 at their pc_write.
REQ-019 ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SLT 0101, SRL 0110, SLTU 0111, XOR 1000, SRA 1001, MUL 1010, MULH 1011, MULHSU 1100, MULHU 1101; load/store/U/J use 0000; BEQ/BNE 0001; BLT/BGE 0101; BLTU/BGEU 0111.
REQ-020 Multiply (ENABLE_MUL=1): remain in EXECUTE until mul_done=1, then WB; mul_done ignored in all other states.
REQ-021 MEM: load mem_read=1, store mem_write=1, held until dmem_ready; load -> WB; store -> FETCH with pc_write=1, pc_src=0.
REQ-022 WB: reg_write=1 exactly one cycle, pc_write=1 (pc_src per REQ-018), next FETCH.
REQ-023 Strobes imem_req, ir_write, mem_read, mem_write, reg_write, pc_write are 0 outside the states listed.
REQ-024 Wait counter: cleared on entering FETCH/MEM, increments each non-ready cycle; reaching MEM_TIMEOUT (MEM_TIMEOUT>0) -> TRAP, bus_err=1; ready on the same cycle as limit wins.
REQ-025 TRAP: absorbing; all strobes 0; illegal/bus_err sticky until rst.
REQ-026 instret increments by 1 on every cycle with pc_write=1; wraps modulo 2^CNT_W.

Reset
REQ-027 rst=1 -> next edge: state=FETCH, counters 0, illegal=0, bus_err=0, instret=0, all strobes 0; effective mid-operation, abandoning any in-flight access.
REQ-028 Datapath selects are don't-care during reset, but shall not be X.

Verification
REQ-029 ADD (op 0110011, func3 000, func7 0), imem_ready in cycle 1 -> FETCH,DECODE,EXECUTE,WB; reg_write 1 cycle, alu_ctrl 0000, instret=1.
REQ-030 LW, dmem_ready after 3 cycles -> mem_read high 3 cycles, then WB with write_back_src 01; 5th instr retire increments instret.
REQ-031 BNE with alu_zero=0 -> pc_write=1, pc_src=1 in EXECUTE; alu_zero=1 -> pc_src=0; no reg_write.
REQ-032 ENABLE_MUL=1, MUL (func7 0000001, func3 000), mul_done after 4 cycles -> alu_ctrl 1010, EXECUTE held 4 cycles; ENABLE_MUL=0 same instr -> illegal=1, TRAP.
REQ-033 MEM_TIMEOUT=16, imem_ready never -> bus_err=1 after 16 FETCH cycles; rst=1 -> FETCH, flags cleared.
REQ-034 rst asserted during MEM of SW -> mem_write 0 next cycle, state FETCH, instret 0.
